spi_slave: RTL

- SPI responder (slave) for the team's SPI master, same mode conventions (cpol/cpha), MSB first, DATA_WITH-bit frames.
- Oversamples the external sclk/ss_n/mosi pins in the system clock domain, assembles received words, shifts transmit words out on miso.
- Sits between the SPI pins and an on-chip register/bus interface.
- Uses a one-word transmit buffer with a ready flag and a one-cycle receive-done tick.

---
 rtl/spi_slave.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/ss_n/mosi in the clk domain, assembles MSB-first
// words into dout and shifts the one-word transmit buffer out on miso.
module spi_slave #(
  parameter int DATA_WITH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [DATA_WITH-1:0] din,
  input  logic                 wr_en,
  input  logic                 cpol,
  input  logic                 cpha,
  output logic [DATA_WITH-1:0] dout,
  output logic                 spi_done_tick,
  output logic                 tx_ready,
  input  logic                 sclk,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe
);
  localparam int CW = $clog2(DATA_WITH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WITH - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             sclk_pipe_q, sclk_pipe_d, ss_pipe_q, ss_pipe_d;
  logic [1:0]             mosi_pipe_q, mosi_pipe_d;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
  logic                   skip_q, skip_d, reload_q, reload_d;
  logic                   tick_q, tick_d, tx_ready_q, tx_ready_d;
  logic [CW-1:0]          n_q, n_d;
  logic [DATA_WITH-1:0]   rx_q, rx_d, tx_sh_q, tx_sh_d;
  logic [DATA_WITH-1:0]   buf_q, buf_d, dout_q, dout_d;
  logic                   sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;
  logic                   sample_s, shift_s, consume_s;
  logic [DATA_WITH-1:0]   next_word_s, rx_next_s;

  // Synchronizer shifts and edge decode in the clk domain
  always_comb begin
    sclk_pipe_d = {sclk_pipe_q[1:0], sclk};
    ss_pipe_d   = {ss_pipe_q[1:0], ss_n};
    mosi_pipe_d = {mosi_pipe_q[0], mosi};
    sclk_rise_s = sclk_pipe_q[1] & ~sclk_pipe_q[2];
    sclk_fall_s = ~sclk_pipe_q[1] & sclk_pipe_q[2];
    ss_rise_s   = ss_pipe_q[1] & ~ss_pipe_q[2];
    ss_fall_s   = ~ss_pipe_q[1] & ss_pipe_q[2];
    if (cpol_q == cpha_q) begin
      sample_s = sclk_rise_s;
      shift_s  = sclk_fall_s;
    end else begin
      sample_s = sclk_fall_s;
      shift_s  = sclk_rise_s;
    end
    next_word_s = tx_ready_q ? {DATA_WITH{1'b0}} : buf_q;
    rx_next_s   = {rx_q[DATA_WITH-2:0], mosi_pipe_q[1]};
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ss_fall_s ? ST_ACTIVE : ST_IDLE;
      ST_ACTIVE: state_d = ss_rise_s ? ST_IDLE : ST_ACTIVE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM output logic: shift registers, bit counter, word completion
  always_comb begin
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    skip_d    = skip_q;
    reload_d  = reload_q;
    n_d       = n_q;
    rx_d      = rx_q;
    tx_sh_d   = tx_sh_q;
    dout_d    = dout_q;
    tick_d    = 1'b0;
    consume_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s) begin
          cpol_d    = cpol;
          cpha_d    = cpha;
          skip_d    = cpha;
          reload_d  = 1'b0;
          n_d       = {CW{1'b0}};
          rx_d      = {DATA_WITH{1'b0}};
          tx_sh_d   = next_word_s;
          consume_s = ~tx_ready_q;
        end else begin
          tx_sh_d = {DATA_WITH{1'b0}};
        end
      end
      ST_ACTIVE: begin
        // An abort outranks a coincident final sample edge, so no tick is emitted
        if (ss_rise_s) begin
          n_d      = {CW{1'b0}};
          skip_d   = 1'b0;
          reload_d = 1'b0;
          tx_sh_d  = {DATA_WITH{1'b0}};
        end else if (sample_s) begin
          rx_d = rx_next_s;
          if (n_q == LAST_BIT) begin
            dout_d   = rx_next_s;
            tick_d   = 1'b1;
            n_d      = {CW{1'b0}};
            reload_d = 1'b1;
          end else begin
            n_d = n_q + 1'b1;
          end
        end else if (shift_s) begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else if (reload_q) begin
            tx_sh_d   = next_word_s;
            consume_s = ~tx_ready_q;
            reload_d  = 1'b0;
          end else begin
            tx_sh_d = {tx_sh_q[DATA_WITH-2:0], 1'b0};
          end
        end else begin
          n_d = n_q;
        end
      end
      default: begin
        tx_sh_d = {DATA_WITH{1'b0}};
      end
    endcase
  end

  // Transmit buffer: a write always lands, even when the old word is consumed
  always_comb begin
    if (wr_en) begin
      buf_d      = din;
      tx_ready_d = 1'b0;
    end else if (consume_s) begin
      buf_d      = buf_q;
      tx_ready_d = 1'b1;
    end else begin
      buf_d      = buf_q;
      tx_ready_d = tx_ready_q;
    end
  end

  // Datapath registers; ss_n history resets low so a select held low through reset is ignored
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_pipe_q <= 3'b000;
      ss_pipe_q   <= 3'b000;
      mosi_pipe_q <= 2'b00;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      skip_q      <= 1'b0;
      reload_q    <= 1'b0;
      tick_q      <= 1'b0;
      tx_ready_q  <= 1'b1;
      n_q         <= {CW{1'b0}};
      rx_q        <= {DATA_WITH{1'b0}};
      tx_sh_q     <= {DATA_WITH{1'b0}};
      buf_q       <= {DATA_WITH{1'b0}};
      dout_q      <= {DATA_WITH{1'b0}};
    end else begin
      sclk_pipe_q <= sclk_pipe_d;
      ss_pipe_q   <= ss_pipe_d;
      mosi_pipe_q <= mosi_pipe_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      skip_q      <= skip_d;
      reload_q    <= reload_d;
      tick_q      <= tick_d;
      tx_ready_q  <= tx_ready_d;
      n_q         <= n_d;
      rx_q        <= rx_d;
      tx_sh_q     <= tx_sh_d;
      buf_q       <= buf_d;
      dout_q      <= dout_d;
    end
  end

  assign dout          = dout_q;
  assign spi_done_tick = tick_q;
  assign tx_ready      = tx_ready_q;
  assign miso          = tx_sh_q[DATA_WITH-1];
  assign miso_oe       = (state_q == ST_ACTIVE);

endmodule
